// File: rtl/data_dmem_pkg.sv
// Shared constants and FSM state type for the int16 capture memory.
package data_dmem_pkg;
   localparam int DW    = 16;
   localparam int AW    = 9;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;
endpackage

// File: rtl/data_dmem_capture_i16_ram.sv
// DEPTH x DW storage: synchronous write, asynchronous read, contents not reset.
module dmem_ram_1w1r
   import data_dmem_pkg::*;
(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rq
);
   logic [DW-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   assign rq = mem[ra];
endmodule

// File: rtl/data_dmem_capture_i16.sv
// Captures a valid/ready stream of int16 words into sequential RAM addresses,
// keeping a word count and a modulo-2^16 checksum.
module data_dmem_capture_i16
   import data_dmem_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   count,
   output logic [DW-1:0] chk,
   input  logic [AW-1:0] rd_a,
   output logic [DW-1:0] rd_q
);
   localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_LEN  = (AW+1)'(1);

   state_t        state_q, state_d;
   logic [AW:0]   target_q, target_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [DW-1:0] chk_q, chk_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          hs_s;
   logic          last_s;

   assign hs_s   = in_valid & in_ready_q;
   assign last_s = (count_q == (target_q - ONE_LEN));

   // Next-state, pointer, count and checksum logic
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      count_d  = count_q;
      ptr_d    = ptr_q;
      chk_d    = chk_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               target_d = (len == '0) ? FULL_LEN : len;
               ptr_d    = '0;
               count_d  = '0;
               chk_d    = '0;
               state_d  = CAPTURE;
            end else begin
               state_d  = IDLE;
            end
         end
         CAPTURE: begin
            if (hs_s) begin
               ptr_d   = ptr_q + AW'(1);
               count_d = count_q + ONE_LEN;
               chk_d   = chk_q + in_data;
            end else begin
               ptr_d   = ptr_q;
            end
            // abort only overrides the DONE transition, never the write itself
            if (abort) begin
               state_d = IDLE;
            end else if (hs_s && last_s) begin
               state_d = DONE;
            end else begin
               state_d = CAPTURE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == CAPTURE);
      busy_d     = (state_d == CAPTURE);
      done_d     = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         target_q   <= '0;
         count_q    <= '0;
         ptr_q      <= '0;
         chk_q      <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         chk_q      <= chk_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   dmem_ram_1w1r u_ram (
      .clk (clk),
      .we  (hs_s),
      .wa  (ptr_q),
      .wd  (in_data),
      .ra  (rd_a),
      .rq  (rd_q)
   );

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign chk      = chk_q;
endmodule

// File: tb/tb_data_dmem_capture_i16.sv
// Randomized scoreboard bench for data_dmem_capture_i16 against a word-level model.
module tb_data_dmem_capture_i16;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  len = 10'd0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'd0;
   logic        in_ready, busy, done;
   logic [9:0]  count;
   logic [15:0] chk;
   logic [8:0]  rd_a = 9'd0;
   logic [15:0] rd_q;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_mem [512];
   bit          m_wr  [512];
   int          m_count = 0;
   logic [15:0] m_sum = 16'd0;
   int          m_ptr = 0;

   int          exp_cnt_q [$];
   logic [15:0] exp_chk_q [$];
   bit          vpat_q [$];
   logic [15:0] dat_q [$];

   data_dmem_capture_i16 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .done(done), .count(count), .chk(chk),
      .rd_a(rd_a), .rd_q(rd_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match a queued expectation
   always @(negedge clk) begin
      if (rst_n && done === 1'b1) begin
         if (exp_cnt_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            check("done_count", 32'(count), 32'(exp_cnt_q.pop_front()));
            check("done_chk", 32'(chk), 32'(exp_chk_q.pop_front()));
         end
      end
   end

   task automatic read_check(input int a);
      rd_a = 9'(a);
      #1;
      if (m_wr[a]) check($sformatf("rd_q[%0d]", a), 32'(rd_q), 32'(m_mem[a]));
   endtask

   task automatic capture(input int ln, input int vpct, input int abort_at, input bit noise);
      int n, acc, cyc;
      bit v, ab, aborted;
      logic [15:0] d;
      n = (ln == 0) ? 512 : ln;
      acc = 0; cyc = 0; aborted = 0;
      len = 10'(ln);
      start = 1'b1;
      abort = noise;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      m_count = 0; m_sum = 16'd0; m_ptr = 0;
      while (acc < n && cyc < 3000 && !aborted) begin
         v = (vpat_q.size() > cyc) ? vpat_q[cyc] : ($urandom_range(99) < vpct);
         d = (v && dat_q.size() > acc) ? dat_q[acc] : 16'($urandom);
         ab = v && (acc + 1 == abort_at);
         in_valid = v; in_data = d; abort = ab;
         start = noise & 1'($urandom_range(1));
         check("in_ready_cap", 32'(in_ready), 32'd1);
         check("busy_cap", 32'(busy), 32'd1);
         if (v && acc == n - 1 && !ab) begin
            exp_cnt_q.push_back(m_count + 1);
            exp_chk_q.push_back(m_sum + d);
         end
         @(posedge clk); #1;
         cyc++;
         if (v) begin
            m_mem[m_ptr] = d; m_wr[m_ptr] = 1'b1;
            m_ptr = (m_ptr + 1) % 512;
            m_count++; m_sum = m_sum + d; acc++;
         end
         if (ab) aborted = 1;
      end
      in_valid = 1'b0; abort = 1'b0;
      start = noise & !aborted;
      if (!aborted && acc < n) check("capture_timeout", 32'(acc), 32'(n));
      if (!aborted && vpat_q.size() != 0) check("cycles_pattern", 32'(cyc), 32'(vpat_q.size()));
      if (!aborted && vpat_q.size() == 0 && vpct == 100) check("cycles_streaming", 32'(cyc), 32'(n));
      check("in_ready_end", 32'(in_ready), 32'd0);
      check("busy_end", 32'(busy), 32'd0);
      check("count_end", 32'(count), 32'(m_count));
      check("chk_end", 32'(chk), 32'(m_sum));
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_idle", 32'(busy), 32'd0);
      check("done_idle", 32'(done), 32'd0);
      check("count_hold", 32'(count), 32'(m_count));
      check("chk_hold", 32'(chk), 32'(m_sum));
      vpat_q.delete();
      dat_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] stream [20];
      stream = '{16'h7FFF, 16'h0C88, 16'h1897, 16'h1446, 16'h0000, 16'h1446, 16'hF99E,
                 16'h0C88, 16'hFCCA, 16'h0000, 16'h0336, 16'hF378, 16'h0662, 16'hEBBA,
                 16'h0000, 16'hEBBA, 16'hE769, 16'hF378, 16'h8000, 16'h0000};
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_chk", 32'(chk), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd0);

      foreach (stream[i]) dat_q.push_back(stream[i]);
      capture(20, 100, 0, 1'b0);
      check("tp1_chk_const", 32'(chk), 32'h0000FFFF);
      read_check(18); read_check(0);
      for (int a = 0; a < 20; a++) read_check(a);

      for (int i = 0; i < 512; i++) dat_q.push_back(16'(i));
      capture(0, 100, 0, 1'b0);
      check("tp2_count_const", 32'(count), 32'd512);
      read_check(511); read_check(0);
      for (int k = 0; k < 8; k++) read_check($urandom_range(511));

      vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      dat_q  = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
      capture(4, 100, 0, 1'b0);
      for (int a = 0; a < 4; a++) read_check(a);

      capture(20, 100, 7, 1'b0);
      check("abort_count", 32'(count), 32'd7);
      for (int a = 0; a < 7; a++) read_check(a);

      for (int t = 0; t < 6; t++) begin
         capture($urandom_range(40, 1), 60, (t == 3) ? 5 : 0, 1'b1);
         for (int k = 0; k < 6; k++) read_check($urandom_range(40));
      end

      len = 10'd20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_count = 0; m_sum = 16'd0; m_ptr = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'($urandom);
         @(posedge clk); #1;
         m_mem[m_ptr] = in_data; m_wr[m_ptr] = 1'b1;
         m_ptr++; m_count++; m_sum = m_sum + in_data;
      end
      in_valid = 1'b0;
      check("pre_rst_count", 32'(count), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_chk", 32'(chk), 32'd0);
      @(negedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      for (int a = 0; a < 5; a++) read_check(a);

      repeat (3) @(posedge clk);
      #1;
      check("done_queue_empty", 32'(exp_cnt_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
